// File: rtl/reset_boot_controller.sv
// Merges power-on, debounced key and UART reset requests into one stretched sys_reset and latches the boot mode.
// Define RESET_KEY_EN to build the key synchronizer/debouncer; otherwise key_reset_n is ignored.
module reset_boot_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STRETCH_CYCLES  = 1024,
    parameter int CNT_BITS        = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_reset_n,
    input  logic       uart_reset,
    input  logic       boot_sw,
    output logic       sys_reset,
    output logic       boot_mode,
    output logic [1:0] reset_cause
);
    // state | meaning
    // HOLD  | sys_reset asserted; stretch counter runs once every source is idle
    // RUN   | sys_reset released; boot_mode frozen until the next reset
    typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_BITS-1:0] SC_LAST = CNT_BITS'(STRETCH_CYCLES - 1);

    state_t              state;
    logic [CNT_BITS-1:0] sc;
    logic                bs_meta;
    logic                bs_sync;
    logic                key_evt;
    logic                key_act;
    logic                src_act;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bs_meta <= 1'b0;
            bs_sync <= 1'b0;
        end else begin
            bs_meta <= boot_sw;
            bs_sync <= bs_meta;
        end
    end

`ifdef RESET_KEY_EN
    localparam logic [CNT_BITS-1:0] DC_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic                ks_meta;
    logic                ks;
    logic                kd;
    logic                kd_d;
    logic [CNT_BITS-1:0] dc;

    // The key idles released, so the whole chain resets high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ks_meta <= 1'b1;
            ks      <= 1'b1;
            kd      <= 1'b1;
            kd_d    <= 1'b1;
            dc      <= '0;
        end else begin
            ks_meta <= key_reset_n;
            ks      <= ks_meta;
            kd_d    <= kd;
            if (ks == kd) begin
                dc <= '0;
            end else if (dc == DC_LAST) begin
                kd <= ks;
                dc <= '0;
            end else begin
                dc <= dc + 1'b1;
            end
        end
    end

    assign key_evt = kd_d & ~kd;
    assign key_act = ~kd;
`else
    logic key_unused;
    assign key_unused = key_reset_n;
    assign key_evt    = 1'b0;
    assign key_act    = 1'b0;
`endif

    assign src_act = key_act | uart_reset;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HOLD;
            sc          <= '0;
            sys_reset   <= 1'b1;
            boot_mode   <= 1'b0;
            reset_cause <= 2'b00;
        end else begin
            case (state)
                HOLD: begin
                    if (src_act) begin
                        sc <= '0;
                    end else if (sc == SC_LAST) begin
                        state     <= RUN;
                        sys_reset <= 1'b0;
                        boot_mode <= bs_sync;
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                RUN: begin
                    // Cause is captured only here, so requests arriving during HOLD never overwrite it.
                    if (key_evt | uart_reset) begin
                        state       <= HOLD;
                        sc          <= '0;
                        sys_reset   <= 1'b1;
                        reset_cause <= {uart_reset, key_evt};
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

endmodule
